sum_post_stage: RTL and testbench
=================================

SUM_POST_STAGE -- requirements
Module: sum_post_stage

Interface
REQ-001 Parameter: width, default 24, operand width in bits; ports below use 1-based indexing [width:1].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream beat (p, P, G, cin) valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 p  input  width  per-bit propagate (a^b), bit-aligned with P/G.
REQ-007 P  input  width  prefix group propagate, P[i] spans bits 1..i.
REQ-008 G  input  width  prefix group generate, G[i] spans bits 1..i.
REQ-009 cin  input  1  carry into bit 1.
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 sum  output  width  registered sum.
REQ-013 cout  output  1  registered carry out of bit width.
REQ-014 ovf  output  1  registered signed (two's complement) overflow.
REQ-015 zero  output  1  registered flag, sum == 0.
REQ-016 beat_cnt  output  16  count of results consumed downstream (out_valid & out_ready), wraps 0xFFFF -> 0.

Function
REQ-017 Carry: c[1]=cin; c[i]=G[i-1] | (P[i-1] & cin) for i=2..width; cout=G[width] | (P[width] & cin).
REQ-018 Sum: sum[i]=p[i] ^ c[i]; ovf=c[width] ^ cout; zero=~|sum; all computed combinationally, then registered.
REQ-019 Accept: a beat is taken when in_valid & in_ready; no-op otherwise; inputs are don't-care when in_valid=0.
REQ-020 Latency: accepted beat shows on outputs with out_valid=1 at the next rising edge if the output register is free or being drained.
REQ-021 Buffering: 2-entry FIFO (output register + skid register); strict in-order delivery; no beat dropped or duplicated.
REQ-022 State machine: EMPTY (0 entries), ONE (1), FULL (2).
REQ-023 EMPTY: accept -> ONE; else stay.
REQ-024 ONE: accept & drain -> ONE (new beat to output register); accept only -> FULL; drain only -> EMPTY; neither -> stay.
REQ-025 FULL: drain -> ONE (skid entry moves to output register); else stay; no accept possible.
REQ-026 in_ready=1 in EMPTY and ONE, 0 in FULL and while rst=1; registered-state based only, no combinational path from out_ready.
REQ-027 out_valid=1 in ONE and FULL; sum/cout/ovf/zero hold stable while out_valid=1 and out_ready=0.
REQ-028 beat_cnt increments by 1 per drain, including a drain coinciding with an accept.

Reset
REQ-029 rst=1 at an edge: state -> EMPTY, out_valid=0, sum=0, cout=0, ovf=0, zero=0, beat_cnt=0, skid contents discarded.
REQ-030 Reset mid-operation discards all buffered beats; in_ready=1 in the first cycle after rst deasserts; rst overrides any coincident accept or drain.

Verification (width=24; bench derives p=a^b, g=a&b and drives P/G from a reference prefix model)
REQ-031 a=0xFFFFFF, b=0x000001, cin=0, out_ready=1 -> next cycle sum=0x000000, cout=1, ovf=0, zero=1.
REQ-032 a=0x7FFFFF, b=0x000001, cin=0 -> sum=0x800000, cout=0, ovf=1, zero=0.
REQ-033 a=0x123456, b=0x654321, cin=1 -> sum=0x777778, cout=0, ovf=0, zero=0.
REQ-034 out_ready=0, three back-to-back beats offered -> two accepted, in_ready=0 after the second accept; out_ready=1 -> results out in order, beat_cnt=2.
REQ-035 FULL state, rst=1 for one cycle -> out_valid=0, beat_cnt=0, in_ready=1 next cycle, no stale beat appears.
REQ-036 Continuous in_valid=1, out_ready=1 for 70000 beats -> one result per cycle, in_ready never drops, beat_cnt wraps to 70000-65536=4464.

Source files
------------

// File: rtl/sum_post_stage.sv
// Sum post-processing stage of a parallel-prefix adder. Turns per-bit propagate and
// prefix group propagate/generate into sum, carry-out, signed overflow and zero flag.
// The result goes into a 2-entry valid/ready buffer: an output register plus a skid
// register. in_ready depends only on registered state and rst.
module sum_post_stage #(
  parameter int unsigned width = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width:1]   p,
  input  logic [width:1]   P,
  input  logic [width:1]   G,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width:1]   sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [15:0]      beat_cnt
);

  // Result record layout: {zero, ovf, cout, sum}
  localparam int unsigned ResW = width + 3;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [ResW-1:0]   out_q, out_d;
  logic [ResW-1:0]   skid_q, skid_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [width:1]    carry;
  logic [width:1]    sum_c;
  logic              cout_c;
  logic [ResW-1:0]   res_c;
  logic              accept;
  logic              drain;

  // Carry into each bit from the prefix tree, then the sum and flags
  always_comb begin
    carry  = {G[width-1:1] | (P[width-1:1] & {(width-1){cin}}), cin};
    cout_c = G[width] | (P[width] & cin);
    sum_c  = p ^ carry;
    res_c  = {~|sum_c, carry[width] ^ cout_c, cout_c, sum_c};
  end

  // Handshake decode; in_ready is from registered state only
  always_comb begin
    in_ready  = (state_q != StFull) && !rst;
    out_valid = (state_q != StEmpty);
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready;
  end

  // Buffer occupancy FSM and data steering
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = drain ? cnt_q + 16'd1 : cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = res_c;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          out_d = res_c;
        end else if (accept) begin
          skid_d  = res_c;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the skid entry can move forward
        if (drain) begin
          out_d   = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum      = out_q[width-1:0];
  assign cout     = out_q[width];
  assign ovf      = out_q[width+1];
  assign zero     = out_q[width+2];
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_sum_post_stage.sv
// Directed bench for sum_post_stage: reset values, a table of hand-computed sums,
// back-pressure with the 2-entry buffer, reset while full, and a long wrapping stream.
module tb_sum_post_stage;

  localparam int unsigned W = 24;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W:1]    p_s;
  logic [W:1]    P_s;
  logic [W:1]    G_s;
  logic          cin_s;
  logic          out_valid;
  logic          out_ready;
  logic [W:1]    sum;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic [15:0]   beat_cnt;

  int checks   = 0;
  int failures = 0;

  sum_post_stage #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p_s),
    .P         (P_s),
    .G         (G_s),
    .cin       (cin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic [23:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference prefix model: drives p, P, G from the operands
  task automatic set_beat(input logic [23:0] a, input logic [23:0] b, input logic c);
    logic [W:1] pp;
    logic [W:1] gg;
    pp = a ^ b;
    gg = a & b;
    P_s[1] = pp[1];
    G_s[1] = gg[1];
    for (int i = 2; i <= int'(W); i++) begin
      P_s[i] = pp[i] & P_s[i-1];
      G_s[i] = gg[i] | (pp[i] & G_s[i-1]);
    end
    p_s   = pp;
    cin_s = c;
  endtask

  // Arithmetic reference: {zero, ovf, cout, sum}
  function automatic logic [26:0] exp_res(input logic [23:0] a, input logic [23:0] b,
                                          input logic c);
    logic [24:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {24'd0, c};
    v = (a[23] == b[23]) && (s[23] != a[23]);
    return {(s[23:0] == 24'd0), v, s[24], s[23:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [26:0] e;
  int          ready_drops;
  int          valid_drops;
  int          data_errs;

  initial begin
    vecs[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{24'h123456, 24'h654321, 1'b1, 24'h777778, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{24'h000000, 24'h000000, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{24'h400000, 24'h400000, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_beat(24'h0, 24'h0, 1'b0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table: one beat per cycle, downstream always ready
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      set_beat(vecs[k].a, vecs[k].b, vecs[k].cin);
      #1;
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_sum", k), 32'(sum), 32'(vecs[k].sum));
      check($sformatf("vec%0d_cout", k), 32'(cout), 32'(vecs[k].cout));
      check($sformatf("vec%0d_ovf", k), 32'(ovf), 32'(vecs[k].ovf));
      check($sformatf("vec%0d_zero", k), 32'(zero), 32'(vecs[k].zero));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("table_drained", 32'(out_valid), 32'd0);
    check("table_beat_cnt", 32'(beat_cnt), 32'd8);

    // Back-pressure: three beats offered, two taken, delivered in order
    do_reset();
    check("bp_cnt_cleared", 32'(beat_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(vecs[0].a, vecs[0].b, vecs[0].cin);
    @(negedge clk);
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    set_beat(vecs[1].a, vecs[1].b, vecs[1].cin);
    @(negedge clk);
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    set_beat(vecs[2].a, vecs[2].b, vecs[2].cin);
    @(negedge clk);
    check("bp_ready_still_low", 32'(in_ready), 32'd0);
    check("bp_hold_sum", 32'(sum), 32'(vecs[0].sum));
    check("bp_hold_zero", 32'(zero), 32'(vecs[0].zero));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_sum", 32'(sum), 32'(vecs[1].sum));
    check("bp_second_ovf", 32'(ovf), 32'(vecs[1].ovf));
    @(negedge clk);
    check("bp_no_third", 32'(out_valid), 32'd0);
    check("bp_beat_cnt", 32'(beat_cnt), 32'd2);

    // Reset while full, with a coincident accept attempt and drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(vecs[3].a, vecs[3].b, vecs[3].cin);
    @(negedge clk);
    set_beat(vecs[5].a, vecs[5].b, vecs[5].cin);
    @(negedge clk);
    check("full_before_rst", 32'(in_ready), 32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_blocks_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("frst_out_valid", 32'(out_valid), 32'd0);
    check("frst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("frst_sum", 32'(sum), 32'd0);
    check("frst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("frst_no_stale", 32'(out_valid), 32'd0);
    check("frst_cnt_hold", 32'(beat_cnt), 32'd0);

    // Long stream: one result per cycle, counter wraps
    ready_drops = 0;
    valid_drops = 0;
    data_errs   = 0;
    out_ready   = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      logic [23:0] a;
      logic [23:0] b;
      logic        c;
      a = 24'(i * 32'h1F3);
      b = 24'(i * 32'h9E37 + 5);
      c = 1'(i & 1);
      in_valid = 1'b1;
      set_beat(a, b, c);
      #1;
      if (in_ready !== 1'b1) ready_drops++;
      e = exp_res(a, b, c);
      @(negedge clk);
      if (out_valid !== 1'b1) valid_drops++;
      if ({zero, ovf, cout, sum} !== e) data_errs++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_ready_drops", 32'(ready_drops), 32'd0);
    check("stream_valid_drops", 32'(valid_drops), 32'd0);
    check("stream_data_errs", 32'(data_errs), 32'd0);
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_beat_cnt_wrap", 32'(beat_cnt), 32'd4464);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
